id_ex_stage: RTL and testbench
==============================

ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 Parameter DW, default 32, datapath word width.
REQ-002 clk  in  1  rising-edge clock; single clock domain.
REQ-003 rst  in  1  synchronous, active-high reset.
REQ-004 id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite, id_Branch, id_RegDst, id_ALUSrc  in  1 each  decoded control from the ID-stage decoder.
REQ-005 id_ALUOp  in  4  ALU operation code; id_Jump  in  2  (00 none, 01 jr, 10 jr-forwarded, 11 jal).
REQ-006 id_rs, id_rt, id_rd, id_shamt  in  5 each  instruction register fields.
REQ-007 id_rdata1, id_rdata2, id_imm, id_pc4  in  DW each  register reads, sign-extended immediate, PC+4.
REQ-008 flush  in  1  squash the instruction currently in ID (taken branch or jump).
REQ-009 ex_* outputs  out  same widths as REQ-004..REQ-007  registered copies for EX.
REQ-010 ex_dest  out  5  registered destination register number.
REQ-011 previous_rd  out  5  destination of the instruction now in EX, fed back to the decoder.
REQ-012 stall  out  1  combinational load-use hazard; holds PC and IF/ID when 1.
REQ-013 bubble_count  out  16  saturating count of inserted bubbles.

Function
REQ-014 Destination select: id_Jump==11 -> 31; else id_RegDst==1 -> id_rt; else id_rd.
REQ-015 jal SHALL latch ex_RegWrite=1 regardless of id_RegWrite, so the link write occurs.
REQ-016 stall = ex_MemRead & (ex_dest!=0) & (ex_dest==id_rs | ex_dest==id_rt) & ~flush.
REQ-017 Each rising edge, priority rst > flush > stall > load.
REQ-018 Load: all ex_* and ex_dest take ID values (ex_dest per REQ-014); latency exactly one cycle.
REQ-019 Bubble (flush or stall): all ex_ control bits, ex_ALUOp and ex_Jump become 0; ex_dest, field and data outputs become 0.
REQ-020 A stall bubble lasts exactly one cycle; next cycle ex_MemRead=0, so stall deasserts and the held instruction loads.
REQ-021 previous_rd = ex_dest when ex_RegWrite==1, else 0.
REQ-022 bubble_count increments by 1 per bubble cycle, saturates at 16'hFFFF, never wraps.
REQ-023 Simultaneous flush and hazard: one bubble, stall=0, counted once.
REQ-024 ex_dest==0 SHALL never raise stall (writes to $0 are discarded).

Reset
REQ-025 On rst every ex_* output, ex_dest and bubble_count SHALL become 0 at the next edge; previous_rd then 0.
REQ-026 stall SHALL be 0 during and after reset until a load with MemRead=1 is latched.
REQ-027 Reset mid-stall discards the bubble; the ID instruction loads on the first non-reset edge.

Structure
REQ-028 Shared package SHALL hold ALUOp encodings, Jump encodings (JMP_NONE, JMP_JR, JMP_JR_FWD, JMP_JAL) and REG_RA=31.
REQ-029 One sub-module, hazard_detect (combinational REQ-016), SHALL be instantiated; the rest is flat.

Verification
REQ-030 lw $t0(8) in EX, ID add rs=8 -> stall=1 one cycle, ex_RegWrite=0 next edge, add latched the edge after, bubble_count=1.
REQ-031 lw dest 0 in EX, ID rs=0 -> stall=0, normal load.
REQ-032 ID jal (Jump=11, RegWrite=0) -> ex_dest=31, ex_RegWrite=1, previous_rd=31 next cycle.
REQ-033 flush=1 with hazard active -> single bubble, stall=0, bubble_count +1.
REQ-034 Preload bubble_count to 16'hFFFE via 2 + 65532 bubbles, two more -> holds 16'hFFFF.
REQ-035 ID addi RegDst=1 rt=9 rd=3 -> ex_dest=9; assert rst next cycle -> all outputs 0.

Source files
------------

// File: rtl/id_ex_stage_pkg.sv
// Shared encodings and helpers for the ID/EX pipeline register.
package id_ex_stage_pkg;

    localparam logic [4:0] REG_RA = 5'd31;

    typedef enum logic [1:0] {
        JMP_NONE   = 2'b00,
        JMP_JR     = 2'b01,
        JMP_JR_FWD = 2'b10,
        JMP_JAL    = 2'b11
    } jump_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'h0,
        ALU_SUB  = 4'h1,
        ALU_AND  = 4'h2,
        ALU_OR   = 4'h3,
        ALU_XOR  = 4'h4,
        ALU_NOR  = 4'h5,
        ALU_SLT  = 4'h6,
        ALU_SLTU = 4'h7,
        ALU_SLL  = 4'h8,
        ALU_SRL  = 4'h9,
        ALU_SRA  = 4'hA,
        ALU_LUI  = 4'hB
    } alu_op_e;

    typedef struct packed {
        logic       reg_write;
        logic       mem_to_reg;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       reg_dst;
        logic       alu_src;
        logic [3:0] alu_op;
        logic [1:0] jump;
    } ctrl_t;

    // jal links into $ra; otherwise RegDst picks rt (I-type) over rd (R-type).
    function automatic logic [4:0] dest_sel(input logic [1:0] jump, input logic reg_dst,
                                            input logic [4:0] rt, input logic [4:0] rd);
        if (jump == JMP_JAL) return REG_RA;
        if (reg_dst)         return rt;
        return rd;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// ID-side inputs and EX-side outputs of the ID/EX register, bundled as one bus.
interface id_ex_stage_if #(parameter int DW = 32);

    logic          id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite;
    logic          id_Branch, id_RegDst, id_ALUSrc;
    logic [3:0]    id_ALUOp;
    logic [1:0]    id_Jump;
    logic [4:0]    id_rs, id_rt, id_rd, id_shamt;
    logic [DW-1:0] id_rdata1, id_rdata2, id_imm, id_pc4;
    logic          flush;

    logic          ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite;
    logic          ex_Branch, ex_RegDst, ex_ALUSrc;
    logic [3:0]    ex_ALUOp;
    logic [1:0]    ex_Jump;
    logic [4:0]    ex_rs, ex_rt, ex_rd, ex_shamt;
    logic [DW-1:0] ex_rdata1, ex_rdata2, ex_imm, ex_pc4;
    logic [4:0]    ex_dest;
    logic [4:0]    previous_rd;
    logic          stall;
    logic [15:0]   bubble_count;

    modport master (
        output id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite, id_Branch, id_RegDst,
               id_ALUSrc, id_ALUOp, id_Jump, id_rs, id_rt, id_rd, id_shamt,
               id_rdata1, id_rdata2, id_imm, id_pc4, flush,
        input  ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_RegDst,
               ex_ALUSrc, ex_ALUOp, ex_Jump, ex_rs, ex_rt, ex_rd, ex_shamt,
               ex_rdata1, ex_rdata2, ex_imm, ex_pc4, ex_dest, previous_rd, stall, bubble_count
    );

    modport slave (
        input  id_RegWrite, id_MemToReg, id_MemRead, id_MemWrite, id_Branch, id_RegDst,
               id_ALUSrc, id_ALUOp, id_Jump, id_rs, id_rt, id_rd, id_shamt,
               id_rdata1, id_rdata2, id_imm, id_pc4, flush,
        output ex_RegWrite, ex_MemToReg, ex_MemRead, ex_MemWrite, ex_Branch, ex_RegDst,
               ex_ALUSrc, ex_ALUOp, ex_Jump, ex_rs, ex_rt, ex_rd, ex_shamt,
               ex_rdata1, ex_rdata2, ex_imm, ex_pc4, ex_dest, previous_rd, stall, bubble_count
    );

endinterface

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard: a load in EX whose destination is read by the instruction in ID.
module hazard_detect (
    input  logic       ex_mem_read,
    input  logic [4:0] ex_dest,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic       flush,
    output logic       stall
);

    // $0 is never really written, so a load targeting it cannot create a dependency.
    assign stall = ex_mem_read && (ex_dest != 5'd0)
                && ((ex_dest == id_rs) || (ex_dest == id_rt)) && !flush;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection and bubble insertion.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic         clk,
    input  logic         rst,
    id_ex_stage_if.slave bus
);

    ctrl_t         id_ctrl, ex_ctrl;
    logic [4:0]    rs_q, rt_q, rd_q, shamt_q, dest_q;
    logic [DW-1:0] rdata1_q, rdata2_q, imm_q, pc4_q;
    logic [15:0]   bubble_q;
    logic          hazard, stall, bubble;

    hazard_detect u_hazard (
        .ex_mem_read (ex_ctrl.mem_read),
        .ex_dest     (dest_q),
        .id_rs       (bus.id_rs),
        .id_rt       (bus.id_rt),
        .flush       (bus.flush),
        .stall       (hazard)
    );

    assign stall  = hazard && !rst;
    assign bubble = bus.flush || stall;

    // jal forces RegWrite so the link address reaches $ra.
    assign id_ctrl = '{
        reg_write:  bus.id_RegWrite || (bus.id_Jump == JMP_JAL),
        mem_to_reg: bus.id_MemToReg,
        mem_read:   bus.id_MemRead,
        mem_write:  bus.id_MemWrite,
        branch:     bus.id_Branch,
        reg_dst:    bus.id_RegDst,
        alu_src:    bus.id_ALUSrc,
        alu_op:     bus.id_ALUOp,
        jump:       bus.id_Jump
    };

    // NOTE: non-blocking assignments so every register samples pre-edge values together.
    always_ff @(posedge clk) begin
        if (rst || bubble) begin
            ex_ctrl  <= '0;
            rs_q     <= '0;
            rt_q     <= '0;
            rd_q     <= '0;
            shamt_q  <= '0;
            dest_q   <= '0;
            rdata1_q <= '0;
            rdata2_q <= '0;
            imm_q    <= '0;
            pc4_q    <= '0;
        end else begin
            ex_ctrl  <= id_ctrl;
            rs_q     <= bus.id_rs;
            rt_q     <= bus.id_rt;
            rd_q     <= bus.id_rd;
            shamt_q  <= bus.id_shamt;
            dest_q   <= dest_sel(bus.id_Jump, bus.id_RegDst, bus.id_rt, bus.id_rd);
            rdata1_q <= bus.id_rdata1;
            rdata2_q <= bus.id_rdata2;
            imm_q    <= bus.id_imm;
            pc4_q    <= bus.id_pc4;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            bubble_q <= '0;
        else if (bubble && (bubble_q != 16'hFFFF))
            bubble_q <= bubble_q + 16'd1;
    end

    assign bus.ex_RegWrite  = ex_ctrl.reg_write;
    assign bus.ex_MemToReg  = ex_ctrl.mem_to_reg;
    assign bus.ex_MemRead   = ex_ctrl.mem_read;
    assign bus.ex_MemWrite  = ex_ctrl.mem_write;
    assign bus.ex_Branch    = ex_ctrl.branch;
    assign bus.ex_RegDst    = ex_ctrl.reg_dst;
    assign bus.ex_ALUSrc    = ex_ctrl.alu_src;
    assign bus.ex_ALUOp     = ex_ctrl.alu_op;
    assign bus.ex_Jump      = ex_ctrl.jump;
    assign bus.ex_rs        = rs_q;
    assign bus.ex_rt        = rt_q;
    assign bus.ex_rd        = rd_q;
    assign bus.ex_shamt     = shamt_q;
    assign bus.ex_rdata1    = rdata1_q;
    assign bus.ex_rdata2    = rdata2_q;
    assign bus.ex_imm       = imm_q;
    assign bus.ex_pc4       = pc4_q;
    assign bus.ex_dest      = dest_q;
    assign bus.previous_rd  = ex_ctrl.reg_write ? dest_q : 5'd0;
    assign bus.stall        = stall;
    assign bus.bubble_count = bubble_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: a cycle-level model predicts the EX contents and stall.
module tb_id_ex_stage;

    typedef struct packed {
        logic rw, m2r, mr, mw, br, rdst, asrc;
        logic [3:0] aluop;
        logic [1:0] jump;
        logic [4:0] rs, rt, rd, shamt;
        logic [31:0] r1, r2, imm, pc4;
    } id_t;

    typedef struct packed {
        logic rw, m2r, mr, mw, br, rdst, asrc;
        logic [3:0] aluop;
        logic [1:0] jump;
        logic [4:0] rs, rt, rd, shamt;
        logic [31:0] r1, r2, imm, pc4;
        logic [4:0] dest, prev;
        logic [15:0] cnt;
    } ex_t;

    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_bad = 0;
    ex_t  m = '0;
    ex_t  ex_q[$];
    logic stall_q[$];

    always #5 clk = ~clk;

    id_ex_stage_if #(.DW(32)) bus ();

    id_ex_stage #(.DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string name, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, got, exp);
        end
    endtask

    function automatic ex_t sample();
        ex_t s;
        s = '{rw: bus.ex_RegWrite, m2r: bus.ex_MemToReg, mr: bus.ex_MemRead, mw: bus.ex_MemWrite,
              br: bus.ex_Branch, rdst: bus.ex_RegDst, asrc: bus.ex_ALUSrc, aluop: bus.ex_ALUOp,
              jump: bus.ex_Jump, rs: bus.ex_rs, rt: bus.ex_rt, rd: bus.ex_rd, shamt: bus.ex_shamt,
              r1: bus.ex_rdata1, r2: bus.ex_rdata2, imm: bus.ex_imm, pc4: bus.ex_pc4,
              dest: bus.ex_dest, prev: bus.previous_rd, cnt: bus.bubble_count};
        return s;
    endfunction

    // One call per clock: apply ID inputs, then advance the reference model by one edge.
    task automatic drive(input id_t s, input logic f, input logic r);
        ex_t  n;
        logic st;
        @(negedge clk);
        #1;
        rst = r;
        bus.flush = f;
        bus.id_RegWrite = s.rw;   bus.id_MemToReg = s.m2r; bus.id_MemRead = s.mr;
        bus.id_MemWrite = s.mw;   bus.id_Branch = s.br;    bus.id_RegDst = s.rdst;
        bus.id_ALUSrc = s.asrc;   bus.id_ALUOp = s.aluop;  bus.id_Jump = s.jump;
        bus.id_rs = s.rs; bus.id_rt = s.rt; bus.id_rd = s.rd; bus.id_shamt = s.shamt;
        bus.id_rdata1 = s.r1; bus.id_rdata2 = s.r2; bus.id_imm = s.imm; bus.id_pc4 = s.pc4;

        st = !r && !f && m.mr && (m.dest != 5'd0) && (m.dest == s.rs || m.dest == s.rt);
        stall_q.push_back(st);

        n = '0;
        if (r) begin
            n.cnt = 16'd0;
        end else if (f || st) begin
            n.cnt = (m.cnt == 16'hFFFF) ? m.cnt : m.cnt + 16'd1;
        end else begin
            n = '{rw: s.rw || (s.jump == 2'b11), m2r: s.m2r, mr: s.mr, mw: s.mw, br: s.br,
                  rdst: s.rdst, asrc: s.asrc, aluop: s.aluop, jump: s.jump, rs: s.rs, rt: s.rt,
                  rd: s.rd, shamt: s.shamt, r1: s.r1, r2: s.r2, imm: s.imm, pc4: s.pc4,
                  dest: 5'd0, prev: 5'd0, cnt: m.cnt};
            n.dest = (s.jump == 2'b11) ? 5'd31 : (s.rdst ? s.rt : s.rd);
            n.prev = n.rw ? n.dest : 5'd0;
        end
        ex_q.push_back(n);
        m = n;
    endtask

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd8;
            2:       return 5'd9;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic id_t rand_id();
        id_t s;
        s.rw = 1'($urandom_range(0, 1));   s.m2r = 1'($urandom_range(0, 1));
        s.mr = 1'($urandom_range(0, 1));   s.mw = 1'($urandom_range(0, 1));
        s.br = 1'($urandom_range(0, 1));   s.rdst = 1'($urandom_range(0, 1));
        s.asrc = 1'($urandom_range(0, 1)); s.aluop = 4'($urandom_range(0, 15));
        s.jump = 2'($urandom_range(0, 3));
        s.rs = pick_reg(); s.rt = pick_reg(); s.rd = pick_reg();
        s.shamt = 5'($urandom_range(0, 31));
        s.r1 = $urandom; s.r2 = $urandom; s.imm = $urandom; s.pc4 = $urandom;
        return s;
    endfunction

    // Monitor: stall is checked mid-low-phase, EX contents just after each rising edge.
    initial begin
        ex_t  e;
        logic es;
        forever begin
            @(negedge clk);
            #3;
            if (stall_q.size() > 0) begin
                es = stall_q.pop_front();
                check("stall", 256'(bus.stall), 256'(es));
            end
            @(posedge clk);
            #1;
            if (ex_q.size() > 0) begin
                e = ex_q.pop_front();
                check("ex_state", 256'(sample()), 256'(e));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        id_t nop, lw, add, s;
        nop = '0;
        rst = 1'b1;
        drive(nop, 1'b0, 1'b1);
        drive(nop, 1'b0, 1'b1);

        // lw $8 followed by a dependent add: one stall bubble, then the add loads
        lw = nop; lw.rw = 1; lw.m2r = 1; lw.mr = 1; lw.rdst = 1; lw.asrc = 1;
        lw.rs = 5'd4; lw.rt = 5'd8; lw.imm = 32'h10;
        add = nop; add.rw = 1; add.rs = 5'd8; add.rt = 5'd9; add.rd = 5'd10;
        add.r1 = 32'hAAAA_0001; add.pc4 = 32'h104;
        drive(lw, 1'b0, 1'b0);
        drive(add, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("lw_use_bubble_rw", 256'(bus.ex_RegWrite), 256'(0));
        check("lw_use_count", 256'(bus.bubble_count), 256'(1));
        drive(add, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("lw_use_add_dest", 256'(bus.ex_dest), 256'(10));

        // load into $0 never stalls
        s = lw; s.rt = 5'd0;
        drive(s, 1'b0, 1'b0);
        s = add; s.rs = 5'd0; s.rt = 5'd0;
        drive(s, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("lw_zero_no_bubble", 256'(bus.bubble_count), 256'(1));

        // jal with RegWrite=0 still links to $31
        s = nop; s.jump = 2'b11; s.pc4 = 32'h0000_0200;
        drive(s, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("jal_dest", 256'(bus.ex_dest), 256'(31));
        check("jal_rw", 256'(bus.ex_RegWrite), 256'(1));
        check("jal_prev", 256'(bus.previous_rd), 256'(31));

        // flush while a hazard is present: one bubble, no stall
        drive(lw, 1'b0, 1'b0);
        drive(add, 1'b1, 1'b0);
        @(posedge clk); #2;
        check("flush_hazard_count", 256'(bus.bubble_count), 256'(2));
        drive(add, 1'b0, 1'b0);

        // reset in the middle of a stall: held instruction loads on the next edge
        drive(lw, 1'b0, 1'b0);
        drive(add, 1'b0, 1'b1);
        drive(add, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("reset_mid_stall_dest", 256'(bus.ex_dest), 256'(10));

        // addi selects rt, then a reset clears everything
        s = nop; s.rw = 1; s.rdst = 1; s.asrc = 1; s.rt = 5'd9; s.rd = 5'd3; s.imm = 32'h7;
        drive(s, 1'b0, 1'b0);
        @(posedge clk); #2;
        check("addi_dest", 256'(bus.ex_dest), 256'(9));
        drive(s, 1'b0, 1'b1);
        @(posedge clk); #2;
        check("reset_clear", 256'(sample()), 256'(0));

        for (int i = 0; i < 3000; i++) begin
            s = rand_id();
            drive(s, 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 60) == 0));
        end

        // saturation: count up to 16'hFFFE, then beyond
        drive(nop, 1'b0, 1'b1);
        for (int i = 0; i < 65534; i++) drive(nop, 1'b1, 1'b0);
        @(posedge clk); #2;
        check("count_fffe", 256'(bus.bubble_count), 256'(16'hFFFE));
        drive(nop, 1'b1, 1'b0);
        drive(nop, 1'b1, 1'b0);
        @(posedge clk); #2;
        check("count_sat", 256'(bus.bubble_count), 256'(16'hFFFF));
        drive(nop, 1'b1, 1'b0);
        drive(nop, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        #2;
        check("scoreboard_drained", 256'(ex_q.size() + stall_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
